// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Purpose  : Shared types and constants for the ALU-operation controller:
//             ALU/MDU op-code enum, ALUOp encodings, Funct7 patterns and
//             the MUL/DIV sequencer state enum.
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    // Op codes driven onto Operation (zero-extended when OP_W > 5)
    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_SUB    = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SLL    = 5'b00101,
        OP_SRL    = 5'b00110,
        OP_SLT    = 5'b00111,
        OP_BEQ    = 5'b01000,
        OP_SRA    = 5'b01001,
        OP_PASS   = 5'b01010,
        OP_SLTU   = 5'b01011,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    // ALUOp field from the main decoder
    localparam logic [1:0] ALUOP_MEM = 2'b00;   // LW/SW/AUIPC address add
    localparam logic [1:0] ALUOP_BR  = 2'b01;   // branch compare
    localparam logic [1:0] ALUOP_RI  = 2'b10;   // R/I-type, decode by Funct3
    localparam logic [1:0] ALUOP_JMP = 2'b11;   // JAL/LUI pass-through

    // Funct7 patterns
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    // MUL/DIV sequencer state
    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_BUSY = 1'b1
    } seq_state_e;

    // Larger of two latencies, used to size the latency counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Pure combinational decode of ALUOp/Funct3/Funct7/is_rtype into
//             an ALU/MDU op code, an illegal flag and MDU classification.
//             RV32M decode present only when ALU_CTRL_MEXT_EN is defined;
//             otherwise M-encodings decode as illegal.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_rtype,
    output alu_op_e    op,
    output logic       illegal,
    output logic       is_mdu,
    output logic       is_div
);

    logic w_f7_base;
    logic w_f7_alt;
    logic w_alt_ok;

    assign w_f7_base = (funct7 == FUNCT7_BASE);
    assign w_f7_alt  = (funct7 == FUNCT7_ALT);
    // Only ADD/SUB and SRL/SRA have a legal alternate Funct7
    assign w_alt_ok  = w_f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101));

    // Op-code decode; unsupported encodings fall back to AND with illegal set
    always_comb begin
        op      = OP_AND;
        illegal = 1'b0;
        is_mdu  = 1'b0;
        is_div  = 1'b0;
        case (alu_op)
            ALUOP_MEM: op = OP_ADD;
            ALUOP_BR:  op = OP_BEQ;
            ALUOP_JMP: op = OP_PASS;
            default: begin
                if (is_rtype && (funct7 == FUNCT7_MEXT)) begin
`ifdef ALU_CTRL_MEXT_EN
                    op     = alu_op_e'({2'b10, funct3});
                    is_mdu = 1'b1;
                    is_div = funct3[2];
`else
                    illegal = 1'b1;
`endif
                end else if (is_rtype && !w_f7_base && !w_alt_ok) begin
                    illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: op = (is_rtype && w_f7_alt) ? OP_SUB : OP_ADD;
                        3'b001: begin
                            if (w_f7_base) op = OP_SLL;
                            else           illegal = 1'b1;
                        end
                        3'b010: op = OP_SLT;
                        3'b011: op = OP_SLTU;
                        3'b100: op = OP_XOR;
                        3'b101: begin
                            if (w_f7_base)     op = OP_SRL;
                            else if (w_f7_alt) op = OP_SRA;
                            else               illegal = 1'b1;
                        end
                        3'b110: op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end
            end
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_seq
//  Purpose  : Registered ALU-operation controller at the ID/EX boundary with
//             valid/ready handshake, flush, and (with ALU_CTRL_MEXT_EN
//             defined) RV32M decode plus a MUL/DIV latency sequencer that
//             stalls the pipe while the MDU works.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            is_rtype,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] Operation,
    output logic            illegal,
    output logic            mdu_start,
    output logic            mdu_busy
);

    // Parameter sanity checks at elaboration
    if (OP_W < 5) begin : g_chk_op_w
        $error("alu_ctrl_seq: OP_W must be >= 5");
    end
    if ((MUL_LAT < 1) || (DIV_LAT < 1)) begin : g_chk_lat
        $error("alu_ctrl_seq: MUL_LAT and DIV_LAT must be >= 1");
    end

    alu_op_e   w_dec_op;
    logic      w_dec_illegal;
    logic      w_dec_mdu;
    logic      w_dec_div;
    logic      w_accept;
    logic      w_idle;
    logic      w_launch;
    logic      w_done;

    logic            r_out_valid;
    logic [OP_W-1:0] r_op;
    logic            r_illegal;
    logic            r_mdu_start;

    alu_op_decode u_decode (
        .alu_op   (ALUOp),
        .funct3   (Funct3),
        .funct7   (Funct7),
        .is_rtype (is_rtype),
        .op       (w_dec_op),
        .illegal  (w_dec_illegal),
        .is_mdu   (w_dec_mdu),
        .is_div   (w_dec_div)
    );

    assign in_ready = w_idle && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

`ifdef ALU_CTRL_MEXT_EN
    localparam int CNT_W = $clog2(max_u(MUL_LAT, DIV_LAT) + 1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Sequencer state and latency counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SEQ_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: load LAT-1 on MDU launch, count down, finish at zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (w_accept && w_dec_mdu) begin
                    w_state_nxt = SEQ_BUSY;
                    w_cnt_nxt   = w_dec_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                    w_launch    = 1'b1;
                end
            end
            SEQ_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SEQ_IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = SEQ_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = SEQ_IDLE;
            w_cnt_nxt   = '0;
            w_launch    = 1'b0;
            w_done      = 1'b0;
        end
    end

    assign w_idle   = (r_state == SEQ_IDLE);
    assign mdu_busy = (r_state == SEQ_BUSY);
`else
    logic w_unused_mdu;

    // Without RV32M every accepted op completes in one cycle
    assign w_idle       = 1'b1;
    assign w_launch     = 1'b0;
    assign w_done       = 1'b0;
    assign mdu_busy     = 1'b0;
    assign w_unused_mdu = w_dec_mdu ^ w_dec_div;
`endif

    // Output register: capture on accept, present single-cycle results
    // immediately, MDU results when the sequencer finishes, drop on consume
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_illegal   <= 1'b0;
            r_mdu_start <= 1'b0;
        end else begin
            r_mdu_start <= w_launch;
            if (w_accept) begin
                r_op      <= OP_W'(w_dec_op);
                r_illegal <= w_dec_illegal;
            end
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && !w_dec_mdu) begin
                r_out_valid <= 1'b1;
            end else if (w_done) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Operation = r_op;
    assign illegal   = r_illegal;
    assign mdu_start = r_mdu_start;

endmodule : alu_ctrl_seq
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_seq
//  Purpose  : Directed self-checking bench for alu_ctrl_seq: decode table,
//             back-to-back throughput, hold, flush, async reset, and either
//             the MDU sequencer (ALU_CTRL_MEXT_EN) or M-op illegal decode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       is_rtype;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] Operation;
    logic       illegal;
    logic       mdu_start;
    logic       mdu_busy;

    int n_assert;
    int n_fail;

    typedef struct {
        logic [1:0] aop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       rt;
        logic [4:0] op;
        logic       ill;
        string      name;
    } vec_t;

    vec_t vecs[$];

    alu_ctrl_seq #(
        .OP_W    (5),
        .MUL_LAT (3),
        .DIV_LAT (33)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .is_rtype  (is_rtype),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .illegal   (illegal),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [6:0] f7,
                         input logic [2:0] f3, input logic rt);
        in_valid = v;
        ALUOp    = aop;
        Funct7   = f7;
        Funct3   = f3;
        is_rtype = rt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);

        // Decode table: ALUOp, Funct7, Funct3, is_rtype -> op, illegal
        vecs.push_back('{2'b10, 7'b0100000, 3'b000, 1'b1, 5'b00011, 1'b0, "sub"});
        vecs.push_back('{2'b10, 7'b0100000, 3'b000, 1'b0, 5'b00010, 1'b0, "addi"});
        vecs.push_back('{2'b10, 7'b0100000, 3'b101, 1'b0, 5'b01001, 1'b0, "srai"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b001, 1'b1, 5'b00101, 1'b0, "sll"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b010, 1'b1, 5'b00111, 1'b0, "slt"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b011, 1'b1, 5'b01011, 1'b0, "sltu"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b100, 1'b1, 5'b00100, 1'b0, "xor"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b101, 1'b1, 5'b00110, 1'b0, "srl"});
        vecs.push_back('{2'b10, 7'b0100000, 3'b101, 1'b1, 5'b01001, 1'b0, "sra"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b110, 1'b1, 5'b00001, 1'b0, "or"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b111, 1'b1, 5'b00000, 1'b0, "and"});
        vecs.push_back('{2'b10, 7'b0000000, 3'b000, 1'b1, 5'b00010, 1'b0, "add"});
        vecs.push_back('{2'b10, 7'b0100000, 3'b010, 1'b1, 5'b00000, 1'b1, "r_alt_slt_ill"});
        vecs.push_back('{2'b10, 7'b0000010, 3'b101, 1'b1, 5'b00000, 1'b1, "r_bad_f7_ill"});
        vecs.push_back('{2'b10, 7'b1111111, 3'b010, 1'b0, 5'b00111, 1'b0, "slti_f7_ign"});
        vecs.push_back('{2'b10, 7'b0100000, 3'b001, 1'b0, 5'b00000, 1'b1, "slli_alt_ill"});
        vecs.push_back('{2'b00, 7'b0100000, 3'b111, 1'b1, 5'b00010, 1'b0, "aluop00"});
        vecs.push_back('{2'b01, 7'b0000001, 3'b101, 1'b1, 5'b01000, 1'b0, "aluop01"});
        vecs.push_back('{2'b11, 7'b0000001, 3'b011, 1'b0, 5'b01010, 1'b0, "aluop11"});

        // Reset state
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_operation", {27'b0, Operation}, 32'd0);
        chk("rst_illegal",   {31'b0, illegal},   32'd0);
        chk("rst_mdu",       {30'b0, mdu_start, mdu_busy}, 32'd0);
        tick;
        tick;
        reset_n = 1'b1;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

        // Back-to-back single-cycle ops, one per clock
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].aop, vecs[i].f7, vecs[i].f3, vecs[i].rt);
            tick;
            chk({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'd1);
            chk({vecs[i].name, "_op"},    {27'b0, Operation}, {27'b0, vecs[i].op});
            chk({vecs[i].name, "_ill"},   {31'b0, illegal},   {31'b0, vecs[i].ill});
        end

        // Consume with nothing new: out_valid drops
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        tick;
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Hold: downstream stalls for 5 cycles with a new op waiting
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 7'h00, 3'b100, 1'b1);
        tick;
        chk("hold_first_op", {27'b0, Operation}, 32'h04);
        drive(1'b1, 2'b10, 7'h00, 3'b110, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("hold_in_ready", {31'b0, in_ready},  32'd0);
            tick;
            chk("hold_valid",    {31'b0, out_valid}, 32'd1);
            chk("hold_op",       {27'b0, Operation}, 32'h04);
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", {31'b0, in_ready}, 32'd1);
        tick;
        chk("hold_next_op",    {27'b0, Operation}, 32'h01);
        chk("hold_next_valid", {31'b0, out_valid}, 32'd1);

        // Flush beats in_valid; op is accepted on the following cycle
        drive(1'b1, 2'b10, 7'b0100000, 3'b000, 1'b1);
        flush = 1'b1;
        tick;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;
        tick;
        chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
        chk("post_flush_op",    {27'b0, Operation}, 32'h03);

        // Flush while held clears the pending result
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_held_valid", {31'b0, out_valid}, 32'd0);

`ifdef ALU_CTRL_MEXT_EN
        // DIV (F3=100): start pulse cycle 1, busy edges 0..32, valid at edge 33
        drive(1'b1, 2'b10, 7'b0000001, 3'b100, 1'b1);
        tick;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        chk("div_e0_start_busy_valid", {29'b0, mdu_start, mdu_busy, out_valid}, 32'b110);
        chk("div_e0_in_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 1; k < 33; k++) begin
            tick;
            chk("div_wait_start_busy_valid", {29'b0, mdu_start, mdu_busy, out_valid}, 32'b010);
        end
        tick;
        chk("div_done_start_busy_valid", {29'b0, mdu_start, mdu_busy, out_valid}, 32'b001);
        chk("div_done_op", {27'b0, Operation}, 32'h14);
        chk("div_done_ill", {31'b0, illegal}, 32'd0);

        // MUL: latency 3
        drive(1'b1, 2'b10, 7'b0000001, 3'b000, 1'b1);
        tick;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        chk("mul_e0_valid", {31'b0, out_valid}, 32'd0);
        tick;
        tick;
        chk("mul_e2_valid", {31'b0, out_valid}, 32'd0);
        tick;
        chk("mul_e3_valid_busy", {30'b0, out_valid, mdu_busy}, 32'b10);
        chk("mul_e3_op", {27'b0, Operation}, 32'h10);

        // Flush at BUSY cycle 10 with in_valid high
        drive(1'b1, 2'b10, 7'b0000001, 3'b101, 1'b1);
        tick;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        for (int k = 1; k < 10; k++) tick;
        drive(1'b1, 2'b10, 7'h00, 3'b100, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("busy_flush_valid_busy_start", {29'b0, out_valid, mdu_busy, mdu_start}, 32'd0);
        chk("busy_flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        chk("busy_flush_next_valid", {31'b0, out_valid}, 32'd1);
        chk("busy_flush_next_op", {27'b0, Operation}, 32'h04);

        // Async reset mid-BUSY
        drive(1'b1, 2'b10, 7'b0000001, 3'b110, 1'b1);
        tick;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        tick;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy_outs", {27'b0, out_valid, illegal, mdu_start, mdu_busy, 1'b0}, 32'd0);
        chk("rst_busy_op", {27'b0, Operation}, 32'd0);
        tick;
        reset_n = 1'b1;
        tick;
        chk("rst_busy_no_start", {30'b0, mdu_start, mdu_busy}, 32'd0);
`else
        // M-encoding without RV32M: illegal, AND, latency 1, no MDU activity
        drive(1'b1, 2'b10, 7'b0000001, 3'b000, 1'b1);
        tick;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        chk("mop_valid", {31'b0, out_valid}, 32'd1);
        chk("mop_ill",   {31'b0, illegal},   32'd1);
        chk("mop_op",    {27'b0, Operation}, 32'h00);
        chk("mop_mdu",   {30'b0, mdu_start, mdu_busy}, 32'd0);

        // Async reset with a valid result present
        drive(1'b1, 2'b10, 7'b0100000, 3'b000, 1'b1);
        tick;
        drive(1'b0, 2'b00, 7'h00, 3'b000, 1'b0);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_op",    {27'b0, Operation}, 32'd0);
        tick;
        reset_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_alu_ctrl_seq
`default_nettype wire
